// File: rtl/tta_pkg.sv
// Shared constants and FSM encoding for the TTA instruction-line fetch path.
package tta_pkg;

  localparam int LINE_WORDS = 16;
  localparam int LINE_BITS  = 4;
  localparam int INSN_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/tta_iram_dp.sv
// Read-first dual-port block RAM: port A read-only, port B read/write.
// Both ports have one cycle of read latency.
module tta_iram_dp #(
  parameter int W     = 32,
  parameter int AWID  = 9,
  parameter int DEPTH = 512
) (
  input  logic            clock_i,
  input  logic            a_en_i,
  input  logic [AWID-1:0] a_addr_i,
  output logic [W-1:0]    a_data_o,
  input  logic            b_en_i,
  input  logic            b_we_i,
  input  logic [AWID-1:0] b_addr_i,
  input  logic [W-1:0]    b_data_i,
  output logic [W-1:0]    b_data_o
);

  // NOTE: the array and its output registers have no reset so they map onto block RAM.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] a_data_q;
  logic [W-1:0] b_data_q;

  always_ff @(posedge clock_i) begin
    if (a_en_i) a_data_q <= mem[a_addr_i];
  end

  // Read and write share one block so a same-address access returns the old word.
  always_ff @(posedge clock_i) begin
    if (b_en_i) begin
      b_data_q <= mem[b_addr_i];
      if (b_we_i) mem[b_addr_i] <= b_data_i;
    end
  end

  assign a_data_o = a_data_q;
  assign b_data_o = b_data_q;

endmodule

// File: rtl/tta_iline_fetch.sv
// Instruction-line server for the L0 cache: streams 16-word lines out of a
// host-loadable dual-port RAM and flags host writes into the held line.
module tta_iline_fetch
  import tta_pkg::*;
#(
  parameter int IW     = INSN_W,
  parameter int AW     = 16,
  parameter int IAMSB  = 8,
  parameter int IWORDS = 512
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             fetch_i,
  input  logic             abort_i,
  input  logic [AW-1:0]    addr_i,
  output logic             ready_o,
  output logic [IW-1:0]    data_o,
  output logic             invld_o,
  input  logic             h_read_i,
  input  logic             h_write_i,
  input  logic [IAMSB:0]   h_addr_i,
  input  logic [IW-1:0]    h_data_i,
  output logic             h_ready_o,
  output logic [IW-1:0]    h_data_o
);

  localparam int LW = IAMSB + 1 - LINE_BITS;

  fetch_state_e         state_q, state_d;
  logic [LW-1:0]        line_q, line_d;
  logic [LINE_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 rd_vld_q, rd_vld_d;
  logic                 line_valid_q, line_valid_d;
  logic                 ready_q, ready_d;
  logic                 invld_q, invld_d;
  logic                 h_ready_q, h_ready_d;
  logic [IW-1:0]        data_q, data_d;

  logic                 a_en;
  logic [IAMSB:0]       a_addr;
  logic [IW-1:0]        a_rdata;
  logic [IW-1:0]        b_rdata;
  logic                 host_hit;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[AW-1:IAMSB+1], addr_i[LINE_BITS-1:0]};
  assign cnt_inc          = cnt_q + LINE_BITS'(1);

  tta_iram_dp #(
    .W     (IW),
    .AWID  (IAMSB + 1),
    .DEPTH (IWORDS)
  ) u_iram (
    .clock_i  (clock_i),
    .a_en_i   (a_en),
    .a_addr_i (a_addr),
    .a_data_o (a_rdata),
    .b_en_i   (h_read_i | h_write_i),
    .b_we_i   (h_write_i),
    .b_addr_i (h_addr_i),
    .b_data_i (h_data_i),
    .b_data_o (b_rdata)
  );

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves a latch.
    state_d      = state_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    rd_vld_d     = 1'b0;
    line_valid_d = line_valid_q;
    a_en         = 1'b0;
    a_addr       = {line_q, cnt_inc};

    // The held line counts as live while streaming, even before its last beat lands.
    host_hit  = h_write_i && (h_addr_i[IAMSB:LINE_BITS] == line_q)
                && (line_valid_q || state_q != ST_IDLE);
    invld_d   = host_hit;
    h_ready_d = h_read_i | h_write_i;
    ready_d   = rd_vld_q && !abort_i;
    data_d    = ready_d ? a_rdata : data_q;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_i) begin
            a_en         = 1'b1;
            a_addr       = {addr_i[IAMSB:LINE_BITS], {LINE_BITS{1'b0}}};
            line_d       = addr_i[IAMSB:LINE_BITS];
            cnt_d        = '0;
            rd_vld_d     = 1'b1;
            line_valid_d = 1'b0;
            state_d      = ST_BURST;
          end
        end
        ST_BURST: begin
          a_en     = 1'b1;
          rd_vld_d = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_q == LINE_BITS'(LINE_WORDS - 2)) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          // The read of word 15 is still in flight on the first HOLD cycle.
          if (rd_vld_q) line_valid_d = 1'b1;
          if (!fetch_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (host_hit) line_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      line_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      invld_q      <= 1'b0;
      h_ready_q    <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      rd_vld_q     <= rd_vld_d;
      line_valid_q <= line_valid_d;
      ready_q      <= ready_d;
      invld_q      <= invld_d;
      h_ready_q    <= h_ready_d;
      data_q       <= data_d;
    end
  end

  assign ready_o   = ready_q;
  assign data_o    = data_q;
  assign invld_o   = invld_q;
  assign h_ready_o = h_ready_q;
  assign h_data_o  = h_ready_q ? b_rdata : '0;

endmodule
